// File: rtl/shifter_pkg.sv
// Shared definitions for the one-hot-amount shifters: default width, FSM
// states and one-hot amount helpers.
package shifter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic onehot_valid(input logic [DEFAULT_WIDTH-1:0] n);
    return (n != '0) && ((n & (n - DEFAULT_WIDTH'(1))) == '0);
  endfunction

  // N[p]=1 selects a shift of DEFAULT_WIDTH-1-p places.
  function automatic logic [CNT_W-1:0] onehot_to_amount(input logic [DEFAULT_WIDTH-1:0] n);
    logic [CNT_W-1:0] amt;
    amt = '0;
    for (int unsigned i = 0; i < DEFAULT_WIDTH; i++) begin
      if (n[i]) amt = CNT_W'(DEFAULT_WIDTH - 1 - i);
    end
    return amt;
  endfunction

endpackage

// File: rtl/onehot_amount_enc.sv
// Combinational one-hot shift-amount encoder: amount = WIDTH-1-p for N[p]=1,
// valid only when exactly one bit of N is set.
module onehot_amount_enc
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]         N,
  output logic [$clog2(WIDTH)-1:0] amount,
  output logic                     valid
);

  localparam int unsigned AMT_W = $clog2(WIDTH);

  always_comb begin
    amount = '0;
    valid  = (N != '0) && ((N & (N - WIDTH'(1))) == '0);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (N[i]) amount = AMT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/seq_right_shifter.sv
// Sequential right shifter, one place per clock, one-hot shift amount.
// Define SEQ_RSHIFT_ARITH_EN to add the arith port (sign-fill shifting).
module seq_right_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] N,
`ifdef SEQ_RSHIFT_ARITH_EN
  input  logic             arith,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] W
);

  localparam int unsigned AMT_W = $clog2(WIDTH);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   sr;
  logic [AMT_W-1:0]   cnt;
  logic [AMT_W-1:0]   n_amt;
  logic               n_valid;
  logic               fill_bit;

  onehot_amount_enc #(.WIDTH(WIDTH)) u_enc (
    .N      (N),
    .amount (n_amt),
    .valid  (n_valid)
  );

`ifdef SEQ_RSHIFT_ARITH_EN
  logic fill_q;

  // Fill bit is frozen at accept so D/arith may change while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= 1'b0;
    end else if (state == IDLE && start && n_valid) begin
      fill_q <= arith & D[WIDTH-1];
    end
  end

  assign fill_bit = fill_q;
`else
  assign fill_bit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = n_valid ? SHIFT : DONE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      W    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (n_valid) begin
              sr  <= D;
              cnt <= n_amt;
            end else begin
              W    <= '0;
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            sr  <= {fill_bit, sr[WIDTH-1:1]};
            cnt <= cnt - AMT_W'(1);
          end else begin
            W    <= sr;
            err  <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
